// File: rtl/ctrl_pipe_if.sv
// Bundles the D-stage decode inputs, pipeline hazard controls and the staged
// control outputs of ctrl_pipe into one interface.
interface ctrl_pipe_if #(
  parameter int ALUCTL_W = 4
);
  logic [6:0]          OP;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                ValidD;
  logic                StallE;
  logic                FlushE;

  logic [2:0]          Imm_SrcD;
  logic                IllegalD;

  logic                RegWriteE;
  logic                MemWriteE;
  logic                JumpE;
  logic                BranchE;
  logic                ALUSrcE;
  logic                WD3_SrcE;
  logic [1:0]          ResultSrcE;
  logic [ALUCTL_W-1:0] ALUControlE;
  logic [2:0]          BranchF3E;

  logic                RegWriteM;
  logic                MemWriteM;
  logic [1:0]          ResultSrcM;

  logic                RegWriteW;
  logic [1:0]          ResultSrcW;

  logic                MulDivBusy;

  modport master (
    output OP, funct3, funct7, ValidD, StallE, FlushE,
    input  Imm_SrcD, IllegalD,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, WD3_SrcE,
    input  ResultSrcE, ALUControlE, BranchF3E,
    input  RegWriteM, MemWriteM, ResultSrcM,
    input  RegWriteW, ResultSrcW, MulDivBusy
  );

  modport slave (
    input  OP, funct3, funct7, ValidD, StallE, FlushE,
    output Imm_SrcD, IllegalD,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, WD3_SrcE,
    output ResultSrcE, ALUControlE, BranchF3E,
    output RegWriteM, MemWriteM, ResultSrcM,
    output RegWriteW, ResultSrcW, MulDivBusy
  );
endinterface

// File: rtl/ctrl_pipe.sv
// RV32I-style control decode with E/M/W control pipeline registers.
// Define CTRL_PIPE_MULDIV_EN to add mul/div decode and the multi-cycle E occupancy counter.
module ctrl_pipe #(
  parameter int ALUCTL_W   = 4,
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
);

  if (ALUCTL_W < 4) begin : g_alu_w_chk
    $error("ctrl_pipe: ALUCTL_W must be at least 4");
  end
  if (MULDIV_LAT < 2 || MULDIV_LAT > 16) begin : g_lat_chk
    $error("ctrl_pipe: MULDIV_LAT must be in 2..16");
  end

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_SLT  = 4'd4,  ALU_XOR = 4'd5,  ALU_SLL = 4'd6, ALU_SRL = 4'd7,
    ALU_SRA  = 4'd8,  ALU_MUL = 4'd9,  ALU_MULH = 4'd10,
    ALU_DIV  = 4'd11, ALU_REM = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic                rw;
    logic                mw;
    logic                jump;
    logic                branch;
    logic                alu_src;
    logic                wd3_src;
    logic [1:0]          rs;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic [2:0]          br_f3;
  } ctrl_e_t;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] rs;
  } ctrl_m_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
  } ctrl_w_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base integer funct3 mapping; 011 has no mapping here and is rejected by callers.
  function automatic alu_op_e base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  ctrl_e_t    dec;
  alu_op_e    alu_op;
  logic [2:0] imm_src;
  logic       illegal;
`ifdef CTRL_PIPE_MULDIV_EN
  logic       is_muldiv;
`endif

  ctrl_e_t e_d, e_q;
  ctrl_m_t m_d, m_q;
  ctrl_w_t w_d, w_q;
  logic    muldiv_busy;
  logic    load_e;

  always_comb begin
    // NOTE: every decode output gets a default first so no path can infer a latch.
    dec       = '0;
    alu_op    = ALU_ADD;
    imm_src   = 3'b000;
    illegal   = 1'b0;
`ifdef CTRL_PIPE_MULDIV_EN
    is_muldiv = 1'b0;
`endif
    case (bus.OP)
      OP_R: begin
        dec.rw = 1'b1;
        case (bus.funct7)
          F7_BASE: begin
            alu_op  = base_alu(bus.funct3);
            illegal = (bus.funct3 == 3'b011);
          end
          F7_ALT: begin
            case (bus.funct3)
              3'b000:  alu_op  = ALU_SUB;
              3'b101:  alu_op  = ALU_SRA;
              default: illegal = 1'b1;
            endcase
          end
`ifdef CTRL_PIPE_MULDIV_EN
          7'b0000001: begin
            is_muldiv = 1'b1;
            case (bus.funct3)
              3'b000:  alu_op  = ALU_MUL;
              3'b001:  alu_op  = ALU_MULH;
              3'b100:  alu_op  = ALU_DIV;
              3'b110:  alu_op  = ALU_REM;
              default: illegal = 1'b1;
            endcase
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_I_ALU: begin
        dec.rw      = 1'b1;
        dec.alu_src = 1'b1;
        case (bus.funct3)
          3'b001: begin
            alu_op  = ALU_SLL;
            illegal = (bus.funct7 != F7_BASE);
          end
          3'b101: begin
            if (bus.funct7 == F7_BASE)     alu_op  = ALU_SRL;
            else if (bus.funct7 == F7_ALT) alu_op  = ALU_SRA;
            else                           illegal = 1'b1;
          end
          3'b011:  illegal = 1'b1;
          default: alu_op  = base_alu(bus.funct3);
        endcase
      end
      OP_LOAD: begin
        dec.rw      = 1'b1;
        dec.alu_src = 1'b1;
        dec.rs      = 2'b01;
        illegal     = (bus.funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.mw      = 1'b1;
        dec.alu_src = 1'b1;
        imm_src     = 3'b001;
        illegal     = (bus.funct3 != 3'b010);
      end
      OP_BR: begin
        dec.branch = 1'b1;
        dec.br_f3  = bus.funct3;
        imm_src    = 3'b010;
        case (bus.funct3)
          3'b000, 3'b001: alu_op  = ALU_SUB;
          3'b100, 3'b101: alu_op  = ALU_SLT;
          default:        illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.rw      = 1'b1;
        dec.jump    = 1'b1;
        dec.rs      = 2'b10;
        dec.wd3_src = 1'b1;
        imm_src     = 3'b100;
      end
      OP_JALR: begin
        dec.rw      = 1'b1;
        dec.jump    = 1'b1;
        dec.alu_src = 1'b1;
        dec.rs      = 2'b10;
        dec.wd3_src = 1'b1;
      end
      OP_LUI: begin
        dec.rw  = 1'b1;
        dec.rs  = 2'b11;
        imm_src = 3'b011;
      end
      default: illegal = 1'b1;
    endcase
    dec.alu_ctl = ALUCTL_W'(alu_op);
  end

  // Flush beats stall/busy; an empty or illegal D slot becomes a bubble.
  assign load_e = !bus.FlushE && !bus.StallE && !muldiv_busy;

  always_comb begin
    e_d = e_q;
    if (bus.FlushE)                     e_d = '0;
    else if (load_e && bus.ValidD && !illegal) e_d = dec;
    else if (load_e)                    e_d = '0;

    m_d = (bus.StallE || muldiv_busy) ? '0 : ctrl_m_t'{e_q.rw, e_q.mw, e_q.rs};
    w_d = ctrl_w_t'{m_q.rw, m_q.rs};
  end

`ifdef CTRL_PIPE_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_LAT);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // The counter covers the remaining E cycles after the load cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.FlushE)       cnt_d = '0;
    else if (muldiv_busy) cnt_d = cnt_q - CNT_W'(1);
    else if (load_e)      cnt_d = (bus.ValidD && !illegal && is_muldiv) ? CNT_W'(MULDIV_LAT - 1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign muldiv_busy = (cnt_q != '0);
`else
  assign muldiv_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge values together.
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign bus.Imm_SrcD    = imm_src;
  assign bus.IllegalD    = illegal;
  assign bus.RegWriteE   = e_q.rw;
  assign bus.MemWriteE   = e_q.mw;
  assign bus.JumpE       = e_q.jump;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.WD3_SrcE    = e_q.wd3_src;
  assign bus.ResultSrcE  = e_q.rs;
  assign bus.ALUControlE = e_q.alu_ctl;
  assign bus.BranchF3E   = e_q.br_f3;
  assign bus.RegWriteM   = m_q.rw;
  assign bus.MemWriteM   = m_q.mw;
  assign bus.ResultSrcM  = m_q.rs;
  assign bus.RegWriteW   = w_q.rw;
  assign bus.ResultSrcW  = w_q.rs;
  assign bus.MulDivBusy  = muldiv_busy;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a decode/E-stage vector table plus hand-written
// multi-cycle sequences for latency, stall, flush, mul/div occupancy and async reset.
module tb_ctrl_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ctrl_pipe_if #(.ALUCTL_W(4)) bus ();

  ctrl_pipe #(.ALUCTL_W(4), .MULDIV_LAT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    logic [2:0] imm;
    logic [14:0] e;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic v);
    bus.OP     = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.ValidD = v;
  endtask

  // {rw, mw, jump, branch, alu_src, wd3_src, rs[1:0], alu[3:0], br_f3[2:0]}
  function automatic logic [14:0] ev(input logic rw, input logic mw, input logic j, input logic b,
                                     input logic as, input logic wd, input logic [1:0] rs,
                                     input logic [3:0] alu, input logic [2:0] bf3);
    return {rw, mw, j, b, as, wd, rs, alu, bf3};
  endfunction

  function automatic logic [14:0] e_now();
    return {bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.ALUSrcE,
            bus.WD3_SrcE, bus.ResultSrcE, bus.ALUControlE, bus.BranchF3E};
  endfunction

  function automatic logic [31:0] all_ctrl();
    return {e_now(), bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM,
            bus.RegWriteW, bus.ResultSrcW, bus.MulDivBusy};
  endfunction

  function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic ill, input logic [2:0] imm,
                              input logic [14:0] e);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.ill = ill; v.imm = imm; v.e = e;
    return v;
  endfunction

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);

    vecs.push_back(mk("add",   7'b0110011, 3'b000, 7'b0000000, 0, 3'b000, ev(1,0,0,0,0,0,2'b00,4'd0,3'b000)));
    vecs.push_back(mk("sub",   7'b0110011, 3'b000, 7'b0100000, 0, 3'b000, ev(1,0,0,0,0,0,2'b00,4'd1,3'b000)));
    vecs.push_back(mk("sra",   7'b0110011, 3'b101, 7'b0100000, 0, 3'b000, ev(1,0,0,0,0,0,2'b00,4'd8,3'b000)));
    vecs.push_back(mk("and",   7'b0110011, 3'b111, 7'b0000000, 0, 3'b000, ev(1,0,0,0,0,0,2'b00,4'd2,3'b000)));
    vecs.push_back(mk("xor",   7'b0110011, 3'b100, 7'b0000000, 0, 3'b000, ev(1,0,0,0,0,0,2'b00,4'd5,3'b000)));
    vecs.push_back(mk("slt",   7'b0110011, 3'b010, 7'b0000000, 0, 3'b000, ev(1,0,0,0,0,0,2'b00,4'd4,3'b000)));
    vecs.push_back(mk("sltu",  7'b0110011, 3'b011, 7'b0000000, 1, 3'b000, '0));
    vecs.push_back(mk("r_alt_f3_1", 7'b0110011, 3'b001, 7'b0100000, 1, 3'b000, '0));
    vecs.push_back(mk("r_f7_bad", 7'b0110011, 3'b000, 7'b0010000, 1, 3'b000, '0));
    vecs.push_back(mk("addi",  7'b0010011, 3'b000, 7'b0101010, 0, 3'b000, ev(1,0,0,0,1,0,2'b00,4'd0,3'b000)));
    vecs.push_back(mk("slli",  7'b0010011, 3'b001, 7'b0000000, 0, 3'b000, ev(1,0,0,0,1,0,2'b00,4'd6,3'b000)));
    vecs.push_back(mk("slli_bad", 7'b0010011, 3'b001, 7'b0100000, 1, 3'b000, '0));
    vecs.push_back(mk("srli",  7'b0010011, 3'b101, 7'b0000000, 0, 3'b000, ev(1,0,0,0,1,0,2'b00,4'd7,3'b000)));
    vecs.push_back(mk("srai",  7'b0010011, 3'b101, 7'b0100000, 0, 3'b000, ev(1,0,0,0,1,0,2'b00,4'd8,3'b000)));
    vecs.push_back(mk("sri_bad", 7'b0010011, 3'b101, 7'b0000001, 1, 3'b000, '0));
    vecs.push_back(mk("ori",   7'b0010011, 3'b110, 7'b1111111, 0, 3'b000, ev(1,0,0,0,1,0,2'b00,4'd3,3'b000)));
    vecs.push_back(mk("lw",    7'b0000011, 3'b010, 7'b0000000, 0, 3'b000, ev(1,0,0,0,1,0,2'b01,4'd0,3'b000)));
    vecs.push_back(mk("lb",    7'b0000011, 3'b000, 7'b0000000, 1, 3'b000, '0));
    vecs.push_back(mk("sw",    7'b0100011, 3'b010, 7'b0000000, 0, 3'b001, ev(0,1,0,0,1,0,2'b00,4'd0,3'b000)));
    vecs.push_back(mk("sh",    7'b0100011, 3'b001, 7'b0000000, 1, 3'b000, '0));
    vecs.push_back(mk("beq",   7'b1100011, 3'b000, 7'b0000000, 0, 3'b010, ev(0,0,0,1,0,0,2'b00,4'd1,3'b000)));
    vecs.push_back(mk("bne",   7'b1100011, 3'b001, 7'b0000000, 0, 3'b010, ev(0,0,0,1,0,0,2'b00,4'd1,3'b001)));
    vecs.push_back(mk("blt",   7'b1100011, 3'b100, 7'b0000000, 0, 3'b010, ev(0,0,0,1,0,0,2'b00,4'd4,3'b100)));
    vecs.push_back(mk("bge",   7'b1100011, 3'b101, 7'b0000000, 0, 3'b010, ev(0,0,0,1,0,0,2'b00,4'd4,3'b101)));
    vecs.push_back(mk("bltu",  7'b1100011, 3'b110, 7'b0000000, 1, 3'b000, '0));
    vecs.push_back(mk("jal",   7'b1101111, 3'b000, 7'b0000000, 0, 3'b100, ev(1,0,1,0,0,1,2'b10,4'd0,3'b000)));
    vecs.push_back(mk("jalr",  7'b1100111, 3'b000, 7'b0000000, 0, 3'b000, ev(1,0,1,0,1,1,2'b10,4'd0,3'b000)));
    vecs.push_back(mk("lui",   7'b0110111, 3'b000, 7'b0000000, 0, 3'b011, ev(1,0,0,0,0,0,2'b11,4'd0,3'b000)));
    vecs.push_back(mk("bad_op", 7'b1111111, 3'b000, 7'b0000000, 1, 3'b000, '0));

    // Reset state, both before and after clock edges arrive with rst_n low.
    #2;
    check("reset_async", all_ctrl(), 32'h0);
    tick();
    tick();
    check("reset_clocked", all_ctrl(), 32'h0);
    rst_n = 1'b1;

    // Decode and E-stage table.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b1);
      #1;
      check({vecs[i].name, "_illegal"}, 32'(bus.IllegalD), 32'(vecs[i].ill));
      if (!vecs[i].ill) check({vecs[i].name, "_imm"}, 32'(bus.Imm_SrcD), 32'(vecs[i].imm));
      tick();
      check({vecs[i].name, "_e"}, 32'(e_now()), 32'(vecs[i].e));
    end

    // ValidD=0 loads a bubble into E.
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);
    tick();
    check("invalid_bubble_e", 32'(e_now()), 32'h0);

    // Latency: add reaches E, M, W on consecutive edges.
    drive(7'b0110011, 3'b000, 7'b0, 1'b1);
    tick();
    check("lat_e", {bus.RegWriteE, bus.ALUControlE, bus.ALUSrcE}, {1'b1, 4'd0, 1'b0});
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);
    tick();
    check("lat_m", {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RegWriteE}, {1'b1, 1'b0, 2'b00, 1'b0});
    tick();
    check("lat_w", {bus.RegWriteW, bus.ResultSrcW, bus.RegWriteM}, {1'b1, 2'b00, 1'b0});
    tick();
    check("lat_w_drain", 32'(bus.RegWriteW), 32'h0);

    // jal then a two-cycle stall: E holds, M fills with bubbles.
    drive(7'b1101111, 3'b000, 7'b0, 1'b1);
    tick();
    check("jal_e", {bus.JumpE, bus.ResultSrcE, bus.WD3_SrcE}, {1'b1, 2'b10, 1'b1});
    drive(7'b0100011, 3'b010, 7'b0, 1'b1);
    bus.StallE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("stall%0d_e", c), 32'(e_now()), 32'(ev(1,0,1,0,0,1,2'b10,4'd0,3'b000)));
      check($sformatf("stall%0d_m", c), {bus.RegWriteM, bus.MemWriteM}, 2'b00);
    end
    bus.StallE = 1'b0;
    drive(7'b0100011, 3'b010, 7'b0, 1'b0);
    tick();
    check("stall_release_m", {bus.RegWriteM, bus.ResultSrcM, bus.RegWriteE}, {1'b1, 2'b10, 1'b0});

    // Flush wins over stall on the same edge.
    drive(7'b0100011, 3'b010, 7'b0, 1'b1);
    tick();
    check("sw_e", 32'(bus.MemWriteE), 32'h1);
    bus.FlushE = 1'b1;
    bus.StallE = 1'b1;
    tick();
    check("flush_over_stall", 32'(e_now()), 32'h0);
    bus.FlushE = 1'b0;
    bus.StallE = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);
    tick();

`ifdef CTRL_PIPE_MULDIV_EN
    // mul occupies E for MULDIV_LAT=4 cycles, busy for the first 3.
    drive(7'b0110011, 3'b000, 7'b0000001, 1'b1);
    tick();
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("mul_c%0d_busy", c), 32'(bus.MulDivBusy), (c < 4) ? 32'h1 : 32'h0);
      check($sformatf("mul_c%0d_alu", c), {bus.RegWriteE, bus.ALUControlE, bus.RegWriteM}, {1'b1, 4'd9, 1'b0});
      tick();
    end
    check("mul_c5_m", {bus.RegWriteM, bus.RegWriteE}, 2'b10);
    drive(7'b0110011, 3'b110, 7'b0000001, 1'b1);
    #1;
    check("rem_legal", 32'(bus.IllegalD), 32'h0);
    drive(7'b0110011, 3'b010, 7'b0000001, 1'b1);
    #1;
    check("muldiv_f3_bad", 32'(bus.IllegalD), 32'h1);

    // Flush in busy cycle 2 clears E and the counter.
    drive(7'b0110011, 3'b100, 7'b0000001, 1'b1);
    tick();
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);
    check("div_e", {bus.MulDivBusy, bus.ALUControlE}, {1'b1, 4'd11});
    tick();
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    check("div_flush", {bus.MulDivBusy, bus.RegWriteE, bus.RegWriteM}, 3'b000);
    tick();
    check("div_flush_after", {bus.MulDivBusy, bus.RegWriteM}, 2'b00);

    // Async reset while busy.
    drive(7'b0110011, 3'b000, 7'b0000001, 1'b1);
    tick();
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);
    check("mul_busy_pre_reset", 32'(bus.MulDivBusy), 32'h1);
`else
    drive(7'b0110011, 3'b000, 7'b0000001, 1'b1);
    #1;
    check("mul_illegal", 32'(bus.IllegalD), 32'h1);
    tick();
    check("mul_no_busy", {bus.MulDivBusy, bus.RegWriteE}, 2'b00);

    // Async reset with a live instruction in the pipeline.
    drive(7'b0110011, 3'b000, 7'b0, 1'b1);
    tick();
    tick();
    drive(7'b0110011, 3'b000, 7'b0, 1'b0);
    check("pre_reset_live", {bus.RegWriteE, bus.RegWriteM}, 2'b11);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid", all_ctrl(), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset", all_ctrl(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 Parameter ALUCTL_W, default 4, ALU control width; legal values are 4 or more.
REQ-004 Parameter MULDIV_LAT, default 4, cycles a mul/div op occupies E; legal range is 2..16.
REQ-005 OP  input  7 | funct3  input  3 | funct7  input  7  D-stage instruction fields.
REQ-006 ValidD  input  1  D-stage instruction valid.
REQ-007 StallE  input  1  E register hold request.
REQ-008 FlushE  input  1  E register bubble request.
REQ-009 Imm_SrcD  output  3 | IllegalD  output  1  combinational D-stage decode results.
REQ-010 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, WD3_SrcE  output  1 each  E-stage controls.
REQ-011 ResultSrcE  output  2 | ALUControlE  output  ALUCTL_W | BranchF3E  output  3  E-stage controls.
REQ-012 RegWriteM, MemWriteM  output  1 | ResultSrcM  output  2  M-stage controls.
REQ-013 RegWriteW  output  1 | ResultSrcW  output  2  W-stage controls.
REQ-014 MulDivBusy  output  1  E is occupied by an unfinished mul/div op.

Function
REQ-015 OP decode: R 0110011 sets RW=1, ALUSrc=0, RS=00. I-ALU 0010011 sets RW=1, Imm=000, ALUSrc=1, RS=00.
REQ-016 OP decode: load 0000011 sets RW=1, Imm=000, ALUSrc=1, RS=01, ADD. Store 0100011 sets MW=1, Imm=001, ALUSrc=1, ADD.
REQ-017 OP decode: branch 1100011 sets Branch=1, Imm=010, ALUSrc=0. jal 1101111 sets RW=1, Jump=1, Imm=100, RS=10, WD3_Src=1.
REQ-018 OP decode: jalr 1100111 sets RW=1, Jump=1, Imm=000, ALUSrc=1, RS=10, WD3_Src=1, ADD. lui 0110111 sets RW=1, Imm=011, RS=11.
REQ-019 ALU codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5, SLL=6, SRL=7, SRA=8, zero-extended to ALUCTL_W.
REQ-020 R-type with funct7=0 maps funct3 000/001/010/100/101/110/111 to ADD/SLL/SLT/XOR/SRL/OR/AND.
REQ-021 R-type with funct7=0100000 maps funct3 000 to SUB and funct3 101 to SRA.
REQ-022 I-ALU: slli requires funct7=0; srli/srai use funct7 0/0100000; all other funct3 values map as in R-type.
REQ-023 Branch: funct3 000/001 map to SUB, 100/101 map to SLT; funct3 is copied to BranchF3E.
REQ-024 Load/store funct3 other than 010 is illegal.
REQ-025 Any unlisted OP, or any unlisted funct7/funct3 combination, drives IllegalD=1.
REQ-026 Bubble means every enable (RW, MW, Jump, Branch) = 0 and every other field = 0.
REQ-027 E register: FlushE has top priority and loads a bubble. Else StallE or MulDivBusy holds E.
REQ-028 E register (continued): otherwise E loads the decode when ValidD=1 and IllegalD=0, and loads a bubble otherwise.
REQ-029 M register loads E each cycle; it loads a bubble while MulDivBusy=1 or while StallE=1.
REQ-030 W register loads M every cycle.
REQ-031 Latency: a decoded instruction reaches E/M/W 1/2/3 cycles after D when not stalled.

Reset
REQ-032 While rst_n=0, E, M and W all hold bubbles, the mul/div counter is 0 and MulDivBusy=0.
REQ-033 Reset asserted mid-operation, including a busy mul/div, takes effect immediately with no clock edge required.

Configuration
REQ-034 Macro CTRL_PIPE_MULDIV_EN defined: R-type funct7=0000001 maps funct3 000/001/100/110 to MUL=9/MULH=10/DIV=11/REM=12; all other funct3 values are illegal.
REQ-035 With the macro, loading E with a mul/div op sets the counter to MULDIV_LAT-1.
REQ-036 With the macro, MulDivBusy = (counter != 0); the counter decrements each busy cycle, so the op stays in E for exactly MULDIV_LAT cycles.
REQ-037 With the macro, FlushE during busy clears E and the counter, and MulDivBusy reads 0 from the next cycle.
REQ-038 Macro undefined: funct7=0000001 is illegal, MulDivBusy is tied to 0, and no counter is built.

Verification
REQ-039 add (OP=0110011, f3=000, f7=0) with ValidD=1 -> next cycle RegWriteE=1, ALUControlE=0, ALUSrcE=0; RegWriteW=1 three cycles after D.
REQ-040 bne (f3=001) -> BranchE=1, ALUControlE=1, BranchF3E=001; bltu (f3=110) -> IllegalD=1 and E receives a bubble.
REQ-041 jal -> JumpE=1, ResultSrcE=10, WD3_SrcE=1; StallE=1 for 2 cycles holds E and puts bubbles in M (MemWriteM=0, RegWriteM=0).
REQ-042 sw with FlushE=1 and StallE=1 on the same edge -> MemWriteE=0 (flush wins).
REQ-043 MULDIV_EN, MULDIV_LAT=4, mul -> MulDivBusy=1 for 3 cycles, ALUControlE=9 for 4 cycles, RegWriteM=1 on cycle 5; FlushE in busy cycle 2 -> MulDivBusy=0 the next cycle.
REQ-044 rst_n low asynchronously while MulDivBusy=1 -> all enables 0 and MulDivBusy=0 before the next clk edge.
